// File: rtl/imsic_msi_sequencer.sv
// -----------------------------------------------------------------------------
// imsic_msi_sequencer
//
// Collects MSI set-pending requests (target IMSIC, interrupt file, EIID) from
// NR_REQ requesters, picks one per cycle round-robin, buffers it in a small
// FIFO and issues each entry as a single write through the island's AXI-lite
// write master. The write address is the seteipnum_le register of the target
// file: BASE_ADDR + imsic*IMSIC_STRIDE + file*FILE_STRIDE. The write data is
// the zero-extended EIID.
//
// Optional feature macro: IMSIC_MSI_SEQ_TIMEOUT_EN
//   defined   -> watchdog aborts a write that stalls TIMEOUT_CYCLES cycles in
//                the busy handshake; o_timeout pulses and the entry is dropped.
//   undefined -> the sequencer waits on the write master indefinitely and
//                o_timeout is tied low.
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_req_valid       per-requester request valid
//   o_req_ready       per-requester accept (one-hot or zero, combinational)
//   i_req_imsic       per-requester target IMSIC index
//   i_req_file        per-requester target interrupt file
//   i_req_eiid        per-requester interrupt identity
//   o_wr_start        one-cycle start pulse to the write master
//   o_wr_addr         write address, held from start until the write is done
//   o_wr_data         zero-extended EIID, held like o_wr_addr
//   i_wr_busy         write master busy indication
//   o_busy            FIFO non-empty or a write in progress
//   o_drop            pulse: an accepted request was discarded (EIID 0 or
//                     target outside the configured IMSIC/file range)
//   o_timeout         pulse: watchdog abort of the current write
// -----------------------------------------------------------------------------
module imsic_msi_sequencer #(
    parameter int unsigned NR_REQ         = 4,
    parameter int unsigned NR_IMSICS      = 1,
    parameter int unsigned NR_INTP_FILES  = 2,
    parameter int unsigned NR_SRC         = 30,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter logic [63:0] BASE_ADDR      = 64'h0000_0000_2400_0000,
    parameter logic [63:0] IMSIC_STRIDE   = 64'h0000_0000_0000_8000,
    parameter logic [63:0] FILE_STRIDE    = 64'h0000_0000_0000_1000,
`ifdef IMSIC_MSI_SEQ_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 256,
`endif
    localparam int unsigned NR_SRC_LEN = $clog2(NR_SRC),
    localparam int unsigned IMSIC_W    = (NR_IMSICS > 32'd1) ? $clog2(NR_IMSICS) : 32'd1,
    localparam int unsigned FILE_W     = (NR_INTP_FILES > 32'd1) ? $clog2(NR_INTP_FILES) : 32'd1
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [NR_REQ-1:0]                    i_req_valid,
    output logic [NR_REQ-1:0]                    o_req_ready,
    input  logic [NR_REQ-1:0][IMSIC_W-1:0]       i_req_imsic,
    input  logic [NR_REQ-1:0][FILE_W-1:0]        i_req_file,
    input  logic [NR_REQ-1:0][NR_SRC_LEN-1:0]    i_req_eiid,
    output logic                                 o_wr_start,
    output logic [AXI_ADDR_WIDTH-1:0]            o_wr_addr,
    output logic [AXI_DATA_WIDTH-1:0]            o_wr_data,
    input  logic                                 i_wr_busy,
    output logic                                 o_busy,
    output logic                                 o_drop,
    output logic                                 o_timeout
);

    localparam int unsigned PTR_W   = (NR_REQ > 32'd1) ? $clog2(NR_REQ) : 32'd1;
    localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = FIFO_AW + 32'd1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } state_e;

    // Arbitration / FIFO state
    logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [FIFO_AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [AXI_ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [NR_SRC_LEN-1:0]     fifo_eiid_q [FIFO_DEPTH];
    logic                      drop_q;

    // Write sequencing state
    state_e                    state_q;
    logic                      wr_start_q;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr_q;
    logic [AXI_DATA_WIDTH-1:0] wr_data_q;

    // Combinational helpers
    logic                      grant_vld_s;
    logic [PTR_W-1:0]          grant_idx_s;
    logic [PTR_W-1:0]          cand_s;
    logic [NR_REQ-1:0]         ready_s;
    logic                      full_s, accept_s, invalid_s, push_s, pop_s;
    logic [IMSIC_W-1:0]        sel_imsic_s;
    logic [FILE_W-1:0]         sel_file_s;
    logic [NR_SRC_LEN-1:0]     sel_eiid_s;
    logic [AXI_ADDR_WIDTH-1:0] addr_s;

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        cand_s      = '0;
        for (int i = 0; i < int'(NR_REQ); i++) begin
            cand_s = PTR_W'((int'(rr_ptr_q) + i) % int'(NR_REQ));
            if (!grant_vld_s && i_req_valid[cand_s]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Accept/drop decision, address formation and FIFO next-state.
    always_comb begin
        // Fullness is judged on the registered count only, so a pop in the
        // same cycle never opens a slot for a new grant.
        full_s      = (count_q == CNT_W'(FIFO_DEPTH));
        accept_s    = grant_vld_s && !full_s;
        ready_s     = '0;
        if (accept_s) begin
            ready_s[grant_idx_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
        sel_imsic_s = i_req_imsic[grant_idx_s];
        sel_file_s  = i_req_file[grant_idx_s];
        sel_eiid_s  = i_req_eiid[grant_idx_s];
        invalid_s   = (sel_eiid_s == '0)
                   || (32'(sel_imsic_s) >= NR_IMSICS)
                   || (32'(sel_file_s) >= NR_INTP_FILES);
        push_s      = accept_s && !invalid_s;
        pop_s       = (state_q == ST_IDLE) && (count_q != '0);
        addr_s      = AXI_ADDR_WIDTH'(BASE_ADDR)
                    + AXI_ADDR_WIDTH'(sel_imsic_s) * AXI_ADDR_WIDTH'(IMSIC_STRIDE)
                    + AXI_ADDR_WIDTH'(sel_file_s) * AXI_ADDR_WIDTH'(FILE_STRIDE);
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1'b1);
            2'b01:   count_d = count_q - CNT_W'(1'b1);
            default: count_d = count_q;
        endcase
        if (accept_s) begin
            rr_ptr_d = PTR_W'((int'(grant_idx_s) + 1) % int'(NR_REQ));
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Request FIFO, round-robin pointer and drop pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_addr_q[wr_ptr_q] <= addr_s;
                fifo_eiid_q[wr_ptr_q] <= sel_eiid_s;
                wr_ptr_q              <= wr_ptr_q + FIFO_AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + FIFO_AW'(1'b1);
            end
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
            drop_q   <= accept_s && invalid_s;
        end
    end

`ifdef IMSIC_MSI_SEQ_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 32'd1;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             timeout_q;
`endif

    // Write sequencer FSM with registered start/address/data outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            wr_start_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
`ifdef IMSIC_MSI_SEQ_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            wr_start_q <= 1'b0;
`ifdef IMSIC_MSI_SEQ_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        wr_addr_q  <= fifo_addr_q[rd_ptr_q];
                        wr_data_q  <= AXI_DATA_WIDTH'(fifo_eiid_q[rd_ptr_q]);
                        wr_start_q <= 1'b1;
                        state_q    <= ST_START;
                    end
                end
                ST_START: begin
                    state_q <= ST_WAIT_HI;
`ifdef IMSIC_MSI_SEQ_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                end
                ST_WAIT_HI: begin
                    if (i_wr_busy) begin
                        state_q <= ST_WAIT_LO;
`ifdef IMSIC_MSI_SEQ_TIMEOUT_EN
                        tmo_cnt_q <= '0;
                    end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 32'd1)) begin
                        state_q   <= ST_IDLE;
                        timeout_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1'b1);
`endif
                    end
                end
                ST_WAIT_LO: begin
                    if (!i_wr_busy) begin
                        state_q <= ST_IDLE;
`ifdef IMSIC_MSI_SEQ_TIMEOUT_EN
                    end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 32'd1)) begin
                        state_q   <= ST_IDLE;
                        timeout_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1'b1);
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = ready_s;
    assign o_wr_start  = wr_start_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;
    assign o_busy      = (count_q != '0) || (state_q != ST_IDLE);
    assign o_drop      = drop_q;
`ifdef IMSIC_MSI_SEQ_TIMEOUT_EN
    assign o_timeout   = timeout_q;
`else
    assign o_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_imsic_msi_sequencer.sv
// Directed bench for imsic_msi_sequencer (default parameters).
module tb_imsic_msi_sequencer;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        req_valid;
    logic [3:0]        req_ready;
    logic [3:0][0:0]   req_imsic;
    logic [3:0][0:0]   req_file;
    logic [3:0][4:0]   req_eiid;
    logic              wr_start;
    logic [63:0]       wr_addr;
    logic [63:0]       wr_data;
    logic              force_busy;
    logic              auto_busy = 1'b0;
    logic              auto_en;
    logic              wr_busy;
    logic              busy, drop, tmo;

    int total = 0;
    int bad   = 0;

    // event log filled from the clock
    int          start_cnt = 0;
    int          drop_cnt  = 0;
    int          tmo_cnt   = 0;
    int          m_cnt     = 0;
    logic [63:0] got_addr [$];
    logic [63:0] got_data [$];

    always #5 clk = ~clk;

    assign wr_busy = force_busy | auto_busy;

    imsic_msi_sequencer dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_imsic (req_imsic),
        .i_req_file  (req_file),
        .i_req_eiid  (req_eiid),
        .o_wr_start  (wr_start),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .i_wr_busy   (wr_busy),
        .o_busy      (busy),
        .o_drop      (drop),
        .o_timeout   (tmo)
    );

    // record every start, drop and timeout pulse
    always @(negedge clk) begin
        if (wr_start) begin
            start_cnt++;
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
        end
        if (drop) drop_cnt++;
        if (tmo)  tmo_cnt++;
    end

    // simple write master: busy for 3 cycles after each start
    always @(negedge clk) begin
        if (auto_en && wr_start) begin
            auto_busy = 1'b1;
            m_cnt     = 3;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) auto_busy = 1'b0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        total++;
        if ({req_ready, wr_start, busy, drop, tmo} !== 8'h00) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 00000000", {req_ready, wr_start, busy, drop, tmo});
        end
        total++;
        if ({wr_addr, wr_data} !== 128'h0) begin
            bad++;
            $display("FAIL reset_addr_data: got %h %h want 0 0", wr_addr, wr_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int base;
        int n;
        apply_reset();
        auto_en = 1'b1;
        base = got_data.size();
        req_imsic[0] = 1'b0; req_file[0] = 1'b1; req_eiid[0] = 5'd5;
        req_valid = 4'b0001;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL single_ready: got %b want 0001", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        n = 0;
        while (n < 20 && got_data.size() == base) begin
            tick();
            n++;
        end
        total++;
        if (n !== 1) begin
            bad++; $display("FAIL single_latency: got %0d want 1 extra cycle", n);
        end
        if (got_data.size() > base) begin
            total++;
            if (got_addr[base] !== 64'h2400_1000) begin
                bad++; $display("FAIL single_addr: got %h want 24001000", got_addr[base]);
            end
            total++;
            if (got_data[base] !== 64'd5) begin
                bad++; $display("FAIL single_data: got %0d want 5", got_data[base]);
            end
        end
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL single_busy_hi: got %b want 1", busy);
        end
        n = 0;
        while (n < 20 && busy !== 1'b0) begin
            tick();
            n++;
        end
        total++;
        if (busy !== 1'b0 || n !== 4) begin
            bad++; $display("FAIL single_busy_lo: busy %b after %0d want 0 after 4", busy, n);
        end
        repeat (5) tick();
        total++;
        if (got_data.size() - base !== 1) begin
            bad++; $display("FAIL single_count: got %0d starts want 1", got_data.size() - base);
        end
    endtask

    task automatic test_round_robin();
        int base;
        int n;
        logic [3:0]  exp_g [5];
        logic [63:0] exp_d [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_d = '{64'd10, 64'd11, 64'd12, 64'd13, 64'd10};
        apply_reset();
        auto_en = 1'b1;
        base = got_data.size();
        for (int i = 0; i < 4; i++) begin
            req_imsic[i] = 1'b0;
            req_file[i]  = i[0];
            req_eiid[i]  = 5'(10 + i);
        end
        req_valid = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            #1;
            total++;
            if (req_ready !== exp_g[j]) begin
                bad++; $display("FAIL rr_grant%0d: got %b want %b", j, req_ready, exp_g[j]);
            end
            tick();
        end
        #1;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++; $display("FAIL rr_full: got %b want 0000", req_ready);
        end
        req_valid = 4'b0000;
        n = 0;
        while (n < 100 && got_data.size() < base + 5) begin
            tick();
            n++;
        end
        total++;
        if (got_data.size() < base + 5) begin
            bad++; $display("FAIL rr_timeout: got %0d writes want 5", got_data.size() - base);
        end else begin
            for (int j = 0; j < 5; j++) begin
                total++;
                if (got_data[base + j] !== exp_d[j] ||
                    got_addr[base + j] !== (64'h2400_0000 + ((j % 2 == 1) ? 64'h1000 : 64'h0))) begin
                    bad++;
                    $display("FAIL rr_write%0d: got %h/%0d want file %0d data %0d",
                             j, got_addr[base + j], got_data[base + j], j % 2, exp_d[j]);
                end
            end
        end
    endtask

    task automatic test_full();
        int base;
        int k;
        int n;
        apply_reset();
        auto_en    = 1'b0;
        force_busy = 1'b1;
        base = got_data.size();
        req_imsic[1] = 1'b0; req_file[1] = 1'b0;
        k = 1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (k <= 6) begin
                req_valid = 4'b0010; req_eiid[1] = 5'(k);
            end else begin
                req_valid = 4'b0000;
            end
            #1;
            if (cyc == 10) begin
                total++;
                if (req_ready !== 4'b0000) begin
                    bad++; $display("FAIL full_ready: got %b want 0000", req_ready);
                end
            end
            if (req_ready[1]) k++;
            tick();
        end
        total++;
        if (k - 1 !== 5) begin
            bad++; $display("FAIL full_accepted: got %0d want 5", k - 1);
        end
        total++;
        if (got_data.size() - base !== 1 || busy !== 1'b1) begin
            bad++; $display("FAIL full_stalled: starts %0d busy %b want 1 1", got_data.size() - base, busy);
        end
        force_busy = 1'b0;
        auto_en    = 1'b1;
        n = 0;
        while (n < 150 && got_data.size() < base + 6) begin
            if (k <= 6) begin
                req_valid = 4'b0010; req_eiid[1] = 5'(k);
            end else begin
                req_valid = 4'b0000;
            end
            #1;
            if (req_ready[1]) k++;
            tick();
            n++;
        end
        req_valid = 4'b0000;
        total++;
        if (got_data.size() < base + 6) begin
            bad++; $display("FAIL full_drain: got %0d writes want 6", got_data.size() - base);
        end else begin
            for (int j = 0; j < 6; j++) begin
                total++;
                if (got_data[base + j] !== 64'(j + 1) || got_addr[base + j] !== 64'h2400_0000) begin
                    bad++;
                    $display("FAIL full_order%0d: got %h/%0d want 24000000/%0d",
                             j, got_addr[base + j], got_data[base + j], j + 1);
                end
            end
        end
    endtask

    task automatic test_drop();
        int base;
        int dbase;
        apply_reset();
        auto_en    = 1'b1;
        force_busy = 1'b0;
        base  = got_data.size();
        dbase = drop_cnt;
        req_imsic[2] = 1'b0; req_file[2] = 1'b1; req_eiid[2] = 5'd0;
        req_valid = 4'b0100;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++; $display("FAIL drop_ready: got %b want 0100", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        total++;
        if (drop !== 1'b1) begin
            bad++; $display("FAIL drop_pulse: got %b want 1", drop);
        end
        tick();
        total++;
        if (drop !== 1'b0) begin
            bad++; $display("FAIL drop_width: got %b want 0", drop);
        end
        // IMSIC index 1 is outside a single-IMSIC configuration
        req_imsic[3] = 1'b1; req_file[3] = 1'b0; req_eiid[3] = 5'd7;
        req_valid = 4'b1000;
        #1;
        total++;
        if (req_ready !== 4'b1000) begin
            bad++; $display("FAIL drop_imsic_ready: got %b want 1000", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        total++;
        if (drop !== 1'b1) begin
            bad++; $display("FAIL drop_imsic_pulse: got %b want 1", drop);
        end
        repeat (8) tick();
        total++;
        if (got_data.size() !== base || busy !== 1'b0 || drop_cnt - dbase !== 2) begin
            bad++;
            $display("FAIL drop_no_write: starts %0d busy %b drops %0d want 0 0 2",
                     got_data.size() - base, busy, drop_cnt - dbase);
        end
    endtask

    task automatic test_stall();
        int sbase;
        int tbase;
        int n;
        apply_reset();
        auto_en    = 1'b0;
        force_busy = 1'b0;
        sbase = start_cnt;
        tbase = tmo_cnt;
        req_imsic[0] = 1'b0; req_file[0] = 1'b0; req_eiid[0] = 5'd9;
        req_valid = 4'b0001;
        tick();
        req_imsic[1] = 1'b0; req_file[1] = 1'b1; req_eiid[1] = 5'd11;
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0000;
        repeat (300) tick();
`ifdef IMSIC_MSI_SEQ_TIMEOUT_EN
        total++;
        if (tmo_cnt - tbase !== 1 || start_cnt - sbase !== 2) begin
            bad++;
            $display("FAIL stall_timeout: timeouts %0d starts %0d want 1 2", tmo_cnt - tbase, start_cnt - sbase);
        end
`else
        total++;
        if (tmo_cnt - tbase !== 0 || start_cnt - sbase !== 1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL stall_wait: timeouts %0d starts %0d busy %b want 0 1 1",
                     tmo_cnt - tbase, start_cnt - sbase, busy);
        end
`endif
        auto_en    = 1'b1;
        force_busy = 1'b1;
        repeat (2) tick();
        force_busy = 1'b0;
        n = 0;
        while (n < 50 && busy !== 1'b0) begin
            tick();
            n++;
        end
        total++;
        if (busy !== 1'b0 || got_data[got_data.size() - 1] !== 64'd11) begin
            bad++;
            $display("FAIL stall_recover: busy %b last data %0d want 0 11", busy, got_data[got_data.size() - 1]);
        end
    endtask

    task automatic test_reset_mid_write();
        int sbase;
        apply_reset();
        auto_en    = 1'b0;
        force_busy = 1'b1;
        req_imsic[0] = 1'b0; req_file[0] = 1'b0;
        req_valid = 4'b0001;
        for (int k = 1; k <= 3; k++) begin
            req_eiid[0] = 5'(k);
            tick();
        end
        req_valid = 4'b0000;
        repeat (4) tick();
        total++;
        if (busy !== 1'b1 || wr_addr !== 64'h2400_0000) begin
            bad++; $display("FAIL mid_pre: busy %b addr %h want 1 24000000", busy, wr_addr);
        end
        rst = 1'b1;
        tick();
        total++;
        if ({req_ready, wr_start, busy, drop, tmo} !== 8'h00 || {wr_addr, wr_data} !== 128'h0) begin
            bad++;
            $display("FAIL mid_reset: ctrl %b addr %h data %h want all 0",
                     {req_ready, wr_start, busy, drop, tmo}, wr_addr, wr_data);
        end
        rst        = 1'b0;
        force_busy = 1'b0;
        auto_en    = 1'b1;
        sbase      = start_cnt;
        repeat (10) tick();
        total++;
        if (start_cnt !== sbase || busy !== 1'b0) begin
            bad++; $display("FAIL mid_empty: starts %0d busy %b want 0 0", start_cnt - sbase, busy);
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 4'b0000;
        req_imsic  = '0;
        req_file   = '0;
        req_eiid   = '0;
        force_busy = 1'b0;
        auto_en    = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_drop();
        test_stall();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
